// File: rtl/expr_pkg.sv
// ============================================================================
// Module   : expr_pkg
// Brief    : Shared constants, field layout tables and beat type for the
//            expression result unpacker.
// Revision : 1.0
// ============================================================================
`default_nettype none

package expr_pkg;

  localparam int Y_W    = 90;
  localparam int NFIELD = 18;
  localparam int OUT_W  = 8;
  localparam int SIG_W  = 32;
  localparam int CNT_W  = 16;

  localparam logic [SIG_W-1:0] POLY = 32'h04C11DB7;

  // Tables are indexed by field number; element 17 is written first.
  localparam logic [NFIELD-1:0][2:0] FIELD_W = {
    3'd6, 3'd5, 3'd4,  3'd6, 3'd5, 3'd4,  3'd6, 3'd5, 3'd4,
    3'd6, 3'd5, 3'd4,  3'd6, 3'd5, 3'd4,  3'd6, 3'd5, 3'd4
  };

  localparam logic [NFIELD-1:0][6:0] FIELD_OFF = {
    7'd0,  7'd6,  7'd11, 7'd15, 7'd21, 7'd26,
    7'd30, 7'd36, 7'd41, 7'd45, 7'd51, 7'd56,
    7'd60, 7'd66, 7'd71, 7'd75, 7'd81, 7'd86
  };

  // Fields of odd groups (3..5, 9..11, 15..17) carry signed values.
  localparam logic [NFIELD-1:0] FIELD_SGN = 18'h38E38;

  typedef struct packed {
    logic [4:0]       idx;
    logic [OUT_W-1:0] data;
  } field_t;

  function automatic logic [OUT_W-1:0] ext_field(input logic [Y_W-1:0] y,
                                                 input logic [4:0]     i);
    logic [5:0]       raw;
    logic [OUT_W-1:0] r;
    raw = 6'(y >> FIELD_OFF[i]);
    case (FIELD_W[i])
      3'd4:    r = FIELD_SGN[i] ? {{4{raw[3]}}, raw[3:0]} : {4'b0, raw[3:0]};
      3'd5:    r = FIELD_SGN[i] ? {{3{raw[4]}}, raw[4:0]} : {3'b0, raw[4:0]};
      default: r = FIELD_SGN[i] ? {{2{raw[5]}}, raw[5:0]} : {2'b0, raw[5:0]};
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/expression_response_unpacker_if.sv
// ============================================================================
// Module   : expression_response_unpacker_if
// Brief    : Packed-vector input and field-beat output handshakes.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface expression_response_unpacker_if;

  logic                         in_valid;
  logic                         in_ready;
  logic [expr_pkg::Y_W-1:0]     in_y;
  logic                         out_valid;
  logic                         out_ready;
  logic [4:0]                   out_idx;
  logic [expr_pkg::OUT_W-1:0]   out_data;
  logic                         out_last;

  modport master (
    output in_valid, in_y, out_ready,
    input  in_ready, out_valid, out_idx, out_data, out_last
  );

  modport slave (
    input  in_valid, in_y, out_ready,
    output in_ready, out_valid, out_idx, out_data, out_last
  );

endinterface

`default_nettype wire

// File: rtl/expr_misr.sv
// ============================================================================
// Module   : expr_misr
// Brief    : 32-bit MISR over accepted result vectors plus a saturating
//            vector counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module expr_misr import expr_pkg::*; (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear,
  input  wire logic             en,
  input  wire logic [Y_W-1:0]   y,
  output logic      [SIG_W-1:0] sig,
  output logic      [CNT_W-1:0] count
);

  logic [SIG_W-1:0] w_fold;

  assign w_fold = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};

  // Clear takes priority over a coincident transfer.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sig   <= '0;
      count <= '0;
    end else if (en) begin
      sig   <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ w_fold;
      count <= (count == {CNT_W{1'b1}}) ? count : count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/expression_response_unpacker.sv
// ============================================================================
// Module   : expression_response_unpacker
// Brief    : Buffers packed 90-bit result vectors and emits their 18 fields
//            one per beat, extended to 8 bits; signs every accepted vector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module expression_response_unpacker import expr_pkg::*; (
  input  wire logic                  clk,
  input  wire logic                  rst,
  expression_response_unpacker_if.slave bus,
  input  wire logic                  sig_clear,
  output logic      [SIG_W-1:0]      sig,
  output logic      [CNT_W-1:0]      vec_count
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  logic [Y_W-1:0]   r_mem [2];
  logic             r_rd;
  logic             r_wr;
  logic [1:0]       r_count;
  logic             r_in_ready;

  state_t           r_state;
  field_t           r_field;
  logic             r_out_valid;
  logic             r_out_last;

  logic             w_push;
  logic             w_beat;
  logic             w_pop;
  logic [1:0]       w_count_nxt;
  logic [Y_W-1:0]   w_head;
  logic [Y_W-1:0]   w_after;
  logic [OUT_W-1:0] w_next0;
  logic [4:0]       w_idx_inc;
  logic [OUT_W-1:0] w_ext [NFIELD];

  assign w_push      = bus.in_valid && r_in_ready;
  assign w_beat      = r_out_valid && bus.out_ready;
  assign w_pop       = w_beat && r_out_last;
  assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);
  assign w_head      = r_mem[r_rd];
  assign w_idx_inc   = r_field.idx + 5'd1;

  // Vector that becomes head after a pop; an empty slot means the vector
  // being pushed in the same cycle.
  assign w_after = (r_count == 2'd2) ? r_mem[~r_rd] : bus.in_y;
  assign w_next0 = ext_field(w_after, 5'd0);

  for (genvar f = 0; f < NFIELD; f++) begin : g_ext
    assign w_ext[f] = ext_field(w_head, 5'(f));
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= bus.in_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr <= ~r_wr;
      if (w_pop)  r_rd <= ~r_rd;
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_field     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count != 2'd0) begin
            r_state      <= S_EMIT;
            r_out_valid  <= 1'b1;
            r_out_last   <= 1'b0;
            r_field.idx  <= 5'd0;
            r_field.data <= w_ext[0];
          end
        end
        S_EMIT: begin
          if (w_beat) begin
            if (r_out_last) begin
              r_out_last  <= 1'b0;
              r_field.idx <= 5'd0;
              if (w_count_nxt != 2'd0) begin
                r_field.data <= w_next0;
              end else begin
                r_state      <= S_IDLE;
                r_out_valid  <= 1'b0;
                r_field.data <= '0;
              end
            end else begin
              r_field.idx  <= w_idx_inc;
              r_field.data <= w_ext[w_idx_inc];
              r_out_last   <= (w_idx_inc == 5'(NFIELD - 1));
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_idx   = r_field.idx;
  assign bus.out_data  = r_field.data;
  assign bus.out_last  = r_out_last;

  expr_misr u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (sig_clear),
    .en    (w_push),
    .y     (bus.in_y),
    .sig   (sig),
    .count (vec_count)
  );

endmodule

`default_nettype wire

// File: doc/expression_response_unpacker.md
Name: expression_response_unpacker

Overview:
- Consumer end of the 90-bit packed result bus `y = {y0..y17}` produced by the expression_* combinational blocks in the regression suite.
- Accepts packed result vectors over a valid/ready handshake and buffers up to two of them.
- Emits the 18 fields one per beat, each sign- or zero-extended to 8 bits according to the field's declared signedness.
- Compacts every accepted vector into a 32-bit MISR signature that the regression harness compares against golden values.

Parameters:
- `Y_W`, 90, packed result bus width; fixed by the field layout.
- `NFIELD`, 18, number of fields.
- `OUT_W`, 8, width of the extended field on the output stream.
- `SIG_W`, 32, MISR width.
- `POLY`, 32'h04C11DB7, MISR feedback polynomial.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: `in_y` holds a vector.
- `in_ready` output 1: unpacker can accept a vector.
- `in_y` input 90: packed `{y0..y17}`.
- `out_valid` output 1: a field beat is presented.
- `out_ready` input 1: downstream accepts the beat.
- `out_idx` output 5: field index, 0..17.
- `out_data` output 8: extended field value.
- `out_last` output 1: beat is field 17.
- `sig_clear` input 1: zero the signature and the vector count.
- `sig` output 32: MISR value.
- `vec_count` output 16: accepted vectors, saturates at 16'hFFFF.

Behaviour:
- Reset (synchronous, `rst`=1 at a `clk` edge):
  - buffer emptied, state IDLE.
  - `out_valid`=0, `out_idx`=0, `out_data`=0, `out_last`=0.
  - `sig`=0, `vec_count`=0.
  - `in_ready`=1 in the first cycle after reset.
  - Reset mid-stream discards the partial vector and all buffered vectors; no further beats from them.
- Field layout:
  - Field i has width 4, 5, 6 for i mod 3 = 0, 1, 2.
  - Group g = i/3; the group's 15 bits sit at `[89-15g : 75-15g]`, MSB-first in the order y(3g), y(3g+1), y(3g+2).
  - Worked positions: y0=[89:86], y1=[85:81], y2=[80:75], y3=[74:71], y17=[5:0].
- Signedness:
  - Groups with odd g (y3–y5, y9–y11, y15–y17) are signed and sign-extended to 8 bits.
  - All other fields are zero-extended.
- Input buffer and handshake:
  - 2-entry FIFO.
  - `in_ready` = FIFO not full, registered.
  - A transfer occurs when `in_valid` && `in_ready` at a `clk` edge.
  - Simultaneous push and pop when full is not permitted (`in_ready`=0). A push on the same cycle the head is popped while count=1 is legal.
- Output state machine, IDLE → EMIT → IDLE:
  - IDLE: FIFO non-empty → EMIT with idx=0, `out_valid`=1 next cycle. The first beat of a vector accepted into an empty unit appears one cycle after acceptance.
  - EMIT: `out_valid`=1. On `out_valid` && `out_ready`, idx increments.
  - At idx=17 with handshake: pop the head. If the FIFO still holds a vector, restart at idx=0 with no bubble; otherwise return to IDLE.
  - `out_idx`, `out_data` and `out_last` hold stable while `out_valid` && !`out_ready`.
- MISR, updated on each input transfer:
  - `fold` = `in_y[31:0]` ^ `in_y[63:32]` ^ {6'b0, `in_y[89:64]`}.
  - `sig` ← (`sig` << 1) ^ (`sig[31]` ? `POLY` : 0) ^ `fold`.
  - `vec_count` increments on each transfer and saturates at 16'hFFFF.
  - `sig_clear` coincident with a transfer: clear wins. `sig`=0 and `vec_count`=0; that vector is neither folded nor counted.
  - MISR is independent of output backpressure.

Decomposition:
- Shared package `expr_pkg`:
  - `Y_W`, `NFIELD`.
  - Per-field width, offset and signed constants as arrays indexed 0..17.
  - `POLY`.
  - `field_t` typedef holding idx and data.
- One sub-module, `expr_misr` (signature plus saturating counter).
- The FIFO and the field extraction stay inline.

Test Plan:
- Zero vector, `out_ready`=1 constant → 18 beats, `out_idx` 0..17, `out_data`=8'h00, `out_last` only on idx 17.
- `in_y` with y0=4'hF, y3=4'h8, y5=6'h20, y17=6'h3F, other bits 0 → `out_data` idx0=8'h0F, idx3=8'hF8, idx5=8'hE0, idx17=8'hFF; all others 8'h00.
- MISR from reset:
  - vector `in_y`=90'h1 → `sig`=32'h00000001, `vec_count`=1.
  - then zero vector → `sig`=32'h00000002, `vec_count`=2.
  - `sig_clear` pulse → `sig`=0, `vec_count`=0.
- Backpressure:
  - Three vectors offered back-to-back with `out_ready`=0 → first two accepted, `in_ready`=0, third stalled, beat idx0 held stable.
  - Release `out_ready` → 54 beats in order, no bubble between vectors.
- `rst` asserted while at idx 9 of vector A with B buffered → next cycle `out_valid`=0, `in_ready`=1, `sig`=0; a fresh vector restarts at idx 0.
